audio_adc_rx: RTL

Receive-side serial audio deserializer for the audio codec's ADC path, the counterpart of the DAC transmitter. It samples the codec's `bclk`, `adclrc` and `adcdat` lines in the `sys_clk` domain and reassembles I2S-format frames into parallel 24-bit left/right samples. It delivers each stereo pair to downstream logic through a valid/ready handshake. The codec is the clock master; this block only observes `bclk` and `adclrc`.

---
 rtl/audio_pkg.sv | 18 +
 rtl/audio_sync_edge.sv | 46 ++++
 rtl/audio_adc_rx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the codec serial audio ports (ADC receiver and DAC transmitter).
package audio_pkg;

   localparam int   AUDIO_DATA_WIDTH = 24;
   localparam logic LEFT_LRC         = 1'b0;
   localparam logic RIGHT_LRC        = 1'b1;

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } frame_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? 8'hFF : v + 8'd1;
   endfunction

endpackage

// File: rtl/audio_sync_edge.sv
// Multi-stage synchronizer with registered rising-edge detect on edge_i; data_i is
// synchronized alongside and delayed one extra flop so it lines up with rise_o.
module audio_sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter int WIDTH       = 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             edge_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             rise_o
);

   logic [SYNC_STAGES-1:0] edge_sync_q;
   logic [WIDTH-1:0]       data_sync_q [SYNC_STAGES];
   logic                   edge_dly_q;
   logic                   rise_q;
   logic [WIDTH-1:0]       data_dly_q;

   // Synchronizer chains, edge-detect delay flop and aligned data stage.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         edge_sync_q <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            data_sync_q[i] <= '0;
         end
         edge_dly_q <= 1'b0;
         rise_q     <= 1'b0;
         data_dly_q <= '0;
      end else begin
         edge_sync_q    <= {edge_sync_q[SYNC_STAGES-2:0], edge_i};
         data_sync_q[0] <= data_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            data_sync_q[i] <= data_sync_q[i-1];
         end
         edge_dly_q <= edge_sync_q[SYNC_STAGES-1];
         rise_q     <= edge_sync_q[SYNC_STAGES-1] & ~edge_dly_q;
         data_dly_q <= data_sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_o = rise_q;
   assign data_o = data_dly_q;

endmodule

// File: rtl/audio_adc_rx.sv
// I2S receive deserializer for the codec ADC path; delivers left/right pairs over valid/ready.
// Define AUDIO_ADC_RX_OVERRUN_EN to build the sticky overrun flag; otherwise overrun is tied low.
module audio_adc_rx
   import audio_pkg::*;
#(
   parameter int DATA_WIDTH  = AUDIO_DATA_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  bclk,
   input  logic                  adclrc,
   input  logic                  adcdat,
   output logic [DATA_WIDTH-1:0] data_left,
   output logic [DATA_WIDTH-1:0] data_right,
   output logic                  sample_valid,
   input  logic                  sample_ready,
   output logic                  overrun,
   input  logic                  overrun_clr
);

   logic [1:0]            lrc_dat_s;
   logic                  bclk_rise_s;
   logic                  lrc_s;
   logic                  dat_s;
   logic                  lrc_chg_s;
   logic                  publish_s;
   logic                  transfer_s;
   logic [7:0]            bit_idx_d;

   frame_state_e          state_q;
   logic                  prev_lrc_q;
   logic [7:0]            bit_idx_q;
   logic [DATA_WIDTH-1:0] word_q;
   logic [DATA_WIDTH-1:0] left_word_q;
   logic [DATA_WIDTH-1:0] data_left_q;
   logic [DATA_WIDTH-1:0] data_right_q;
   logic                  valid_q;

   audio_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .WIDTH       (2)
   ) u_sync (
      .clk_i   (sys_clk),
      .rst_n_i (sys_rst_n),
      .edge_i  (bclk),
      .data_i  ({adcdat, adclrc}),
      .data_o  (lrc_dat_s),
      .rise_o  (bclk_rise_s)
   );

   assign lrc_s      = lrc_dat_s[0];
   assign dat_s      = lrc_dat_s[1];
   assign lrc_chg_s  = bclk_rise_s && (lrc_s != prev_lrc_q);
   assign publish_s  = lrc_chg_s && (state_q == ST_RIGHT);
   assign transfer_s = valid_q && sample_ready;
   assign bit_idx_d  = sat_inc8(bit_idx_q);

   // Frame FSM, bit capture and output pair registers with the valid/ready handshake.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q      <= ST_SYNC;
         prev_lrc_q   <= LEFT_LRC;
         bit_idx_q    <= 8'd0;
         word_q       <= '0;
         left_word_q  <= '0;
         data_left_q  <= '0;
         data_right_q <= '0;
         valid_q      <= 1'b0;
      end else begin
         if (transfer_s) begin
            valid_q <= 1'b0;
         end
         if (bclk_rise_s) begin
            prev_lrc_q <= lrc_s;
            if (lrc_chg_s) begin
               // The change edge carries the I2S delay bit, so its data is dropped.
               bit_idx_q <= 8'd0;
               word_q    <= '0;
               case (state_q)
                  ST_SYNC: begin
                     if (lrc_s == LEFT_LRC) begin
                        state_q <= ST_LEFT;
                     end
                  end
                  ST_LEFT: begin
                     left_word_q <= word_q;
                     state_q     <= ST_RIGHT;
                  end
                  ST_RIGHT: begin
                     data_left_q  <= left_word_q;
                     data_right_q <= word_q;
                     valid_q      <= 1'b1;
                     state_q      <= ST_LEFT;
                  end
                  default: begin
                     state_q <= ST_SYNC;
                  end
               endcase
            end else begin
               bit_idx_q <= bit_idx_d;
               // Index k lands at bit DATA_WIDTH-k, so short words stay left-aligned.
               for (int i = 0; i < DATA_WIDTH; i++) begin
                  if (bit_idx_d == 8'(DATA_WIDTH - i)) begin
                     word_q[i] <= dat_s;
                  end
               end
            end
         end
      end
   end

`ifdef AUDIO_ADC_RX_OVERRUN_EN
   logic overrun_q;

   // Sticky overrun on a publish over an unaccepted pair; set beats clear.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         overrun_q <= 1'b0;
      end else if (publish_s && valid_q && !sample_ready) begin
         overrun_q <= 1'b1;
      end else if (overrun_clr) begin
         overrun_q <= 1'b0;
      end
   end

   assign overrun = overrun_q;
`else
   assign overrun = 1'b0 & overrun_clr & publish_s;
`endif

   assign data_left    = data_left_q;
   assign data_right   = data_right_q;
   assign sample_valid = valid_q;

endmodule
